// File: rtl/io_interrupt_bank.sv
// Memory-mapped bank of 4-bit interrupt factor/mask register pairs.
// Rising edges on event_in latch factor bits, and masked factors raise per-channel requests.
module io_interrupt_bank #(
  parameter int                    NUM_CHANNELS      = 4,
  parameter int                    ADDR_WIDTH        = 12,
  parameter logic [ADDR_WIDTH-1:0] FACTOR_BASE       = 12'hF00,
  parameter logic [ADDR_WIDTH-1:0] MASK_BASE         = 12'hF10,
  parameter int                    CLEAR_MODE        = 0,
  parameter int                    MASK_GATES_FACTOR = 0,
  localparam int                   IDX_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_WIDTH-1:0]     bus_addr,
  input  logic                      bus_read_en,
  input  logic                      bus_write_en,
  input  logic [3:0]                bus_write_data,
  output logic [3:0]                bus_read_data,
  output logic                      bus_hit,
  input  logic [4*NUM_CHANNELS-1:0] event_in,
  output logic [NUM_CHANNELS-1:0]   irq,
  output logic                      irq_any,
  output logic [IDX_W-1:0]          irq_index
);

  localparam int EW = 4 * NUM_CHANNELS;

  logic [NUM_CHANNELS-1:0][3:0] factor_q, factor_d;
  logic [NUM_CHANNELS-1:0][3:0] mask_q, mask_d;
  logic [EW-1:0]                evt_prev_q, evt_prev_d;
  logic [3:0]                   rd_data_q, rd_data_d;
  logic                         hit_q, hit_d;

  logic [NUM_CHANNELS-1:0]      hit_f, hit_m;
  logic                         rd_access, wr_access;
  logic [EW-1:0]                edge_raw, edge_gate;
  logic [NUM_CHANNELS-1:0][3:0] rise;
  logic [NUM_CHANNELS-1:0][3:0] factor_clr;

  // A simultaneous read and write is treated as a write only.
  assign rd_access = bus_read_en & ~bus_write_en;
  assign wr_access = bus_write_en;

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    hit_f = '0;
    hit_m = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      hit_f[n] = (bus_addr == FACTOR_BASE + ADDR_WIDTH'(n));
      hit_m[n] = (bus_addr == MASK_BASE + ADDR_WIDTH'(n));
    end
  end

  // Edges are qualified by the mask as it stands now, never by a same-cycle mask write.
  assign edge_raw  = event_in & ~evt_prev_q;
  assign edge_gate = (MASK_GATES_FACTOR != 0) ? mask_q : {EW{1'b1}};
  assign rise      = edge_raw & edge_gate;
  assign evt_prev_d = event_in;

  always_comb begin
    factor_d   = factor_q;
    mask_d     = mask_q;
    factor_clr = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      if (CLEAR_MODE == 0) begin
        if (rd_access && hit_f[n]) factor_clr[n] = 4'hF;
      end else begin
        if (wr_access && hit_f[n]) factor_clr[n] = bus_write_data;
      end
      // Set after clear: a new edge on a bit being cleared survives.
      factor_d[n] = (factor_q[n] & ~factor_clr[n]) | rise[n];
      if (wr_access && hit_m[n]) mask_d[n] = bus_write_data;
    end
  end

  always_comb begin
    rd_data_d = '0;
    hit_d     = (bus_read_en | bus_write_en) & ((|hit_f) | (|hit_m));
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      if (rd_access && hit_f[n]) rd_data_d = factor_q[n];
      if (rd_access && hit_m[n]) rd_data_d = mask_q[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      factor_q   <= '0;
      mask_q     <= '0;
      // NOTE: the edge detector loads the live input during reset so a level already high at release is not seen as an edge.
      evt_prev_q <= event_in;
      rd_data_q  <= '0;
      hit_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, independent of statement order.
      factor_q   <= factor_d;
      mask_q     <= mask_d;
      evt_prev_q <= evt_prev_d;
      rd_data_q  <= rd_data_d;
      hit_q      <= hit_d;
    end
  end

  assign bus_read_data = rd_data_q;
  assign bus_hit       = hit_q;

  always_comb begin
    irq       = '0;
    irq_index = '0;
    for (int n = 0; n < NUM_CHANNELS; n++) begin
      irq[n] = |(factor_q[n] & mask_q[n]);
    end
    // Scan downwards so the lowest-numbered pending channel is the one left in irq_index.
    for (int n = NUM_CHANNELS - 1; n >= 0; n--) begin
      if (irq[n]) irq_index = IDX_W'(n);
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_io_interrupt_bank.sv
// Bench for io_interrupt_bank: three instances (read-clear, write-1-clear, mask-gated)
// share one bus and event stimulus and are checked against per-instance reference models.
module tb_io_interrupt_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] bus_addr;
  logic        bus_read_en, bus_write_en;
  logic [3:0]  bus_write_data;
  logic [15:0] event_in;

  logic [3:0]  rd_data [3];
  logic        hit     [3];
  logic [3:0]  irq     [3];
  logic        irq_any [3];
  logic [1:0]  irq_idx [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_interrupt_bank #(.CLEAR_MODE(0), .MASK_GATES_FACTOR(0)) u_dut_rc (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_read_en(bus_read_en),
    .bus_write_en(bus_write_en), .bus_write_data(bus_write_data), .bus_read_data(rd_data[0]),
    .bus_hit(hit[0]), .event_in(event_in), .irq(irq[0]), .irq_any(irq_any[0]), .irq_index(irq_idx[0]));

  io_interrupt_bank #(.CLEAR_MODE(1), .MASK_GATES_FACTOR(0)) u_dut_w1c (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_read_en(bus_read_en),
    .bus_write_en(bus_write_en), .bus_write_data(bus_write_data), .bus_read_data(rd_data[1]),
    .bus_hit(hit[1]), .event_in(event_in), .irq(irq[1]), .irq_any(irq_any[1]), .irq_index(irq_idx[1]));

  io_interrupt_bank #(.CLEAR_MODE(0), .MASK_GATES_FACTOR(1)) u_dut_mg (
    .clk(clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_read_en(bus_read_en),
    .bus_write_en(bus_write_en), .bus_write_data(bus_write_data), .bus_read_data(rd_data[2]),
    .bus_hit(hit[2]), .event_in(event_in), .irq(irq[2]), .irq_any(irq_any[2]), .irq_index(irq_idx[2]));

  // Reference state per instance: 0 = read-clear, 1 = write-1-clear, 2 = mask-gated.
  logic [3:0]  m_fac  [3][4];
  logic [3:0]  m_msk  [3][4];
  logic [15:0] m_prev [3];
  logic [3:0]  m_rd   [3];
  logic        m_hit  [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int a, fch, mch;
    logic [3:0] rise, clr;
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        for (int ch = 0; ch < 4; ch++) begin
          m_fac[k][ch] = 4'h0;
          m_msk[k][ch] = 4'h0;
        end
        m_prev[k] = event_in;
        m_rd[k]   = 4'h0;
        m_hit[k]  = 1'b0;
      end else begin
        a   = int'(bus_addr);
        fch = (a >= 'hF00 && a < 'hF04) ? a - 'hF00 : -1;
        mch = (a >= 'hF10 && a < 'hF14) ? a - 'hF10 : -1;
        m_rd[k]  = 4'h0;
        m_hit[k] = (bus_read_en || bus_write_en) && (fch >= 0 || mch >= 0);
        if (bus_read_en && !bus_write_en) begin
          if (fch >= 0) m_rd[k] = m_fac[k][fch];
          if (mch >= 0) m_rd[k] = m_msk[k][mch];
        end
        for (int ch = 0; ch < 4; ch++) begin
          rise = event_in[4*ch +: 4] & ~m_prev[k][4*ch +: 4];
          if (k == 2) rise = rise & m_msk[k][ch];
          clr = 4'h0;
          if (ch == fch) begin
            if (k != 1 && bus_read_en && !bus_write_en) clr = 4'hF;
            if (k == 1 && bus_write_en) clr = bus_write_data;
          end
          m_fac[k][ch] = (m_fac[k][ch] & ~clr) | rise;
        end
        if (bus_write_en && mch >= 0) m_msk[k][mch] = bus_write_data;
        m_prev[k] = event_in;
      end
    end
  endtask

  task automatic compare_models();
    logic [3:0] e_irq;
    logic [1:0] e_idx;
    for (int k = 0; k < 3; k++) begin
      e_irq = 4'h0;
      e_idx = 2'd0;
      for (int ch = 0; ch < 4; ch++) e_irq[ch] = |(m_fac[k][ch] & m_msk[k][ch]);
      for (int ch = 3; ch >= 0; ch--) if (e_irq[ch]) e_idx = 2'(ch);
      check($sformatf("model%0d_rd", k),  rd_data[k], m_rd[k]);
      check($sformatf("model%0d_hit", k), hit[k],     m_hit[k]);
      check($sformatf("model%0d_irq", k), irq[k],     e_irq);
      check($sformatf("model%0d_any", k), irq_any[k], |e_irq);
      check($sformatf("model%0d_idx", k), irq_idx[k], e_idx);
    end
  endtask

  // One clock: model and DUT see the same pre-edge inputs; outputs sampled 1 unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_models();
  endtask

  task automatic drive(input logic rst_n, input logic [11:0] addr, input logic re, input logic we,
                       input logic [3:0] wd, input logic [15:0] ev);
    reset_n        = rst_n;
    bus_addr       = addr;
    bus_read_en    = re;
    bus_write_en   = we;
    bus_write_data = wd;
    event_in       = ev;
    cycle();
  endtask

  typedef struct {
    logic        rst_n;
    logic [11:0] addr;
    logic        re;
    logic        we;
    logic [3:0]  wd;
    logic [15:0] ev;
    logic [3:0]  e_rd;
    logic        e_hit;
    logic [3:0]  e_irq;
    logic [1:0]  e_idx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic [11:0] addr, input logic re, input logic we,
                     input logic [3:0] wd, input logic [15:0] ev, input logic [3:0] e_rd,
                     input logic e_hit, input logic [3:0] e_irq, input logic [1:0] e_idx);
    vec_t v;
    v = '{rst_n, addr, re, we, wd, ev, e_rd, e_hit, e_irq, e_idx};
    vecs.push_back(v);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_fac[k][ch] = 4'h0;
        m_msk[k][ch] = 4'h0;
      end
      m_prev[k] = 16'h0;
      m_rd[k]   = 4'h0;
      m_hit[k]  = 1'b0;
    end

    // Expected outputs of the read-clear instance after each row's clock edge.
    //   rst  addr     re we wd    ev        rd   hit irq   idx
    add(0, 12'h000, 0, 0, 4'h0, 16'h0001, 4'h0, 0, 4'h0, 2'd0); // reset with ev[0] high
    add(0, 12'h000, 0, 0, 4'h0, 16'h0001, 4'h0, 0, 4'h0, 2'd0);
    for (int i = 0; i < 5; i++)
      add(1, 12'h000, 0, 0, 4'h0, 16'h0001, 4'h0, 0, 4'h0, 2'd0); // held level: no factor
    add(1, 12'hF00, 1, 0, 4'h0, 16'h0001, 4'h0, 1, 4'h0, 2'd0);   // factor ch0 reads 0
    add(1, 12'h000, 0, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 2'd0);
    add(1, 12'h000, 0, 0, 4'h0, 16'h0020, 4'h0, 0, 4'h0, 2'd0);   // edge ch1 bit1, masked
    add(1, 12'hF11, 0, 1, 4'h2, 16'h0000, 4'h0, 1, 4'h2, 2'd1);   // unmask -> irq ch1
    add(1, 12'hF01, 1, 0, 4'h0, 16'h0000, 4'h2, 1, 4'h0, 2'd0);   // read-to-clear
    add(1, 12'hF01, 1, 0, 4'h0, 16'h0000, 4'h0, 1, 4'h0, 2'd0);   // re-read empty
    add(1, 12'hF02, 1, 0, 4'h0, 16'h0100, 4'h0, 1, 4'h0, 2'd0);   // read races edge ch2
    add(1, 12'hF02, 1, 0, 4'h0, 16'h0100, 4'h1, 1, 4'h0, 2'd0);   // edge was kept
    add(1, 12'h000, 0, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h0, 2'd0);
    add(1, 12'h000, 0, 0, 4'h0, 16'h1020, 4'h0, 0, 4'h2, 2'd1);   // ch1 and ch3 pending
    add(1, 12'hF13, 0, 1, 4'hF, 16'h0000, 4'h0, 1, 4'hA, 2'd1);   // unmask ch3
    add(1, 12'hF11, 0, 1, 4'h0, 16'h0000, 4'h0, 1, 4'h8, 2'd3);   // mask ch1 -> index 3
    add(1, 12'hF7F, 1, 0, 4'h0, 16'h0000, 4'h0, 0, 4'h8, 2'd3);   // unmapped read
    add(1, 12'hF03, 1, 0, 4'h0, 16'h0000, 4'h1, 1, 4'h0, 2'd0);
    add(1, 12'hF10, 1, 1, 4'h5, 16'h0000, 4'h0, 1, 4'h0, 2'd0);   // read+write: write wins
    add(1, 12'hF10, 1, 0, 4'h0, 16'h0000, 4'h5, 1, 4'h0, 2'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].wd, vecs[i].ev);
      check($sformatf("vec%0d_rd", i),  rd_data[0], vecs[i].e_rd);
      check($sformatf("vec%0d_hit", i), hit[0],     vecs[i].e_hit);
      check($sformatf("vec%0d_irq", i), irq[0],     vecs[i].e_irq);
      check($sformatf("vec%0d_any", i), irq_any[0], |vecs[i].e_irq);
      check($sformatf("vec%0d_idx", i), irq_idx[0], vecs[i].e_idx);
    end

    // Write-1-to-clear instance: reads are non-destructive.
    drive(0, 12'h000, 0, 0, 4'h0, 16'h0000);
    drive(0, 12'h000, 0, 0, 4'h0, 16'h0000);
    drive(1, 12'h000, 0, 0, 4'h0, 16'h5000);
    drive(1, 12'hF03, 1, 0, 4'h0, 16'h0000);
    check("w1c_first_read", rd_data[1], 4'h5);
    drive(1, 12'hF03, 0, 1, 4'h1, 16'h0000);
    check("w1c_write_hit", hit[1], 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 12'hF03, 1, 0, 4'h0, 16'h0000);
      check($sformatf("w1c_read%0d", i), rd_data[1], 4'h4);
    end

    // Mask-gated instance: edges only latch while the current mask bit is set.
    drive(0, 12'h000, 0, 0, 4'h0, 16'h0000);
    drive(1, 12'h000, 0, 0, 4'h0, 16'h0001);
    drive(1, 12'hF10, 0, 1, 4'hF, 16'h0000);
    drive(1, 12'hF00, 1, 0, 4'h0, 16'h0000);
    check("mg_masked_edge", rd_data[2], 4'h0);
    drive(1, 12'hF10, 0, 1, 4'h0, 16'h0000);
    drive(1, 12'hF10, 0, 1, 4'h1, 16'h0001);
    drive(1, 12'hF00, 1, 0, 4'h0, 16'h0001);
    check("mg_same_cycle_mask", rd_data[2], 4'h0);
    drive(1, 12'h000, 0, 0, 4'h0, 16'h0000);
    drive(1, 12'h000, 0, 0, 4'h0, 16'h0001);
    check("mg_irq", irq[2], 4'h1);
    drive(1, 12'hF00, 1, 0, 4'h0, 16'h0001);
    check("mg_unmasked_edge", rd_data[2], 4'h1);
    drive(1, 12'hF7F, 1, 0, 4'h0, 16'h0001);
    check("mg_unmapped_rd", rd_data[2], 4'h0);
    check("mg_unmapped_hit", hit[2], 1'b0);

    // Randomised traffic, checked against the models every cycle.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [11:0] addr;
      sel = $urandom_range(0, 9);
      if (sel < 4)       addr = 12'hF00 + 12'(sel);
      else if (sel < 8)  addr = 12'hF10 + 12'(sel - 4);
      else if (sel == 8) addr = 12'hF04 + 12'($urandom_range(0, 11));
      else               addr = 12'($urandom);
      drive(($urandom_range(0, 199) != 0), addr, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), 4'($urandom),
            event_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_interrupt_bank.md
Name: io_interrupt_bank

Overview:
- Parametrised, memory-mapped bank of interrupt factor and mask registers on the CPU data bus.
- Generalises the fixed clock and stopwatch factor/mask handling to NUM_CHANNELS channels of 4 factor bits each.
- Each factor bit is set on a rising edge of its event input. Factors clear either on read or by writing 1s, selected by parameter.
- Drives per-channel interrupt requests, a combined request and a priority index into the CPU interrupt logic.

Parameters:
- NUM_CHANNELS, 4, number of 4-bit factor/mask channel pairs (1..16).
- ADDR_WIDTH, 12, CPU data-bus address width.
- FACTOR_BASE, 12'hF00, address of channel 0 factor register; channel n at FACTOR_BASE+n.
- MASK_BASE, 12'hF10, address of channel 0 mask register; channel n at MASK_BASE+n. The two ranges must not overlap.
- CLEAR_MODE, 0, factor clear mode:
  - 0 = read-to-clear; writes to factor addresses are ignored.
  - 1 = write-1-to-clear; reads are non-destructive.
- MASK_GATES_FACTOR, 0, factor latching mode:
  - 0 = factor latches regardless of mask.
  - 1 = factor bit latches only while its mask bit is 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- bus_addr  input  ADDR_WIDTH  CPU data address
- bus_read_en  input  1  read strobe, one cycle per access
- bus_write_en  input  1  write strobe, one cycle per access
- bus_write_data  input  4  write nibble
- bus_read_data  output  4  registered read nibble
- bus_hit  output  1  registered; 1 when the previous-cycle access decoded to this block
- event_in  input  4*NUM_CHANNELS  level event sources; channel n uses bits [4n+3:4n]
- irq  output  NUM_CHANNELS  per-channel request, |(factor[n] & mask[n])
- irq_any  output  1  OR of irq
- irq_index  output  max(1,$clog2(NUM_CHANNELS))  lowest-numbered channel with irq set; 0 when none

Behaviour:
- Reset is synchronous on reset_n low. Reset values:
  - all factors 0, all masks 0;
  - bus_read_data 0, bus_hit 0;
  - irq, irq_any, irq_index 0.
- During reset, the event edge detector register loads event_in. A level already high at reset release produces no factor.
- Edge detect: a bit is set in factor the cycle after a sample where event_in=1 and the previous sample=0. Levels held high never re-set a cleared bit.
- Address decode:
  - hit_f(n) when bus_addr == FACTOR_BASE+n; hit_m(n) when bus_addr == MASK_BASE+n.
  - Addresses outside both ranges are ignored: bus_read_data returns 0 and bus_hit is 0.
- Read latency is 1 cycle: bus_read_data and bus_hit are valid the cycle after bus_read_en.
  - bus_read_data is 0 on any cycle without a decoded read.
- Mask register: read/write. A write takes effect the cycle after bus_write_en. The read value is the register contents before any same-cycle update.
- Factor register:
  - Reads return the 4-bit factor. Writes never set bits.
  - CLEAR_MODE=0: a read clears all 4 bits of that channel at the same edge that registers the data.
  - CLEAR_MODE=1: a write clears the bits where bus_write_data=1.
- Simultaneous clear and new edge on the same bit: the new edge wins and the bit ends at 1. A read returns the pre-edge value, so no event is lost.
- bus_read_en and bus_write_en both high: the write is performed and the read is ignored (bus_read_data 0).
- MASK_GATES_FACTOR=1: the edge is qualified by the current mask register value. A mask write in the same cycle does not qualify that edge.
- irq, irq_any and irq_index are combinational from the factor and mask registers, so they change the cycle after the register update.
- Reset asserted mid-access aborts the access; no clear is applied.

Test Plan:
- Reset with event_in[0]=1 held, release, hold 5 cycles -> factor ch0 reads 4'h0, irq_any=0.
- NUM_CHANNELS=4, CLEAR_MODE=0: pulse event_in[5], write 4'h2 to MASK_BASE+1 -> irq=4'b0010, irq_index=1. Read FACTOR_BASE+1 -> bus_read_data=4'h2 next cycle. Re-read -> 4'h0, irq=0.
- Read FACTOR_BASE+2 in the same cycle as a rising edge on event_in[8] -> read returns 4'h0; the next read returns 4'h1.
- CLEAR_MODE=1: set factor ch3 bits 0 and 2 -> reads 4'h5. Write 4'h1 -> reads 4'h4. Two further reads -> still 4'h4.
- Channels 1 and 3 both pending and unmasked -> irq_index=1. Write mask ch1 to 0 -> irq_index=3 the cycle after.
- MASK_GATES_FACTOR=1 with mask ch0=0: pulse event_in[0], then set mask -> factor ch0 reads 4'h0. Read of unmapped address 12'hF7F -> bus_read_data=0, bus_hit=0.
